pipe_stage_skid: RTL

//   Parametrised pipeline stage register for any inter-stage boundary
//   (IF/ID, ID/EX, EX/MEM, MEM/WB). Replaces the free-running stage registers.

---
 rtl/pipe_stage_skid.sv | 113 +++++++++++
 1 files changed

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline stage with a 2-entry skid buffer; 1-cycle latency, 1 payload/cycle sustained.
// Backpressure: in_ready comes straight from state flops (low only when both entries are full), so out_ready never reaches it combinationally.
module pipe_stage_skid #(
  parameter int DATA_W      = 237,
  parameter bit BUBBLE_ZERO = 1'b1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  main_dat_q;
  logic [DATA_W-1:0]  skid_dat_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic               in_xfer, out_xfer;
  logic               ld_main_in, ld_main_skid, ld_skid;

  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign occupancy = {state_q == S_TWO, state_q == S_ONE};
  assign stall_cnt = stall_cnt_q;
  assign out_data  = (BUBBLE_ZERO && !out_valid) ? '0 : main_dat_q;

  always_comb begin
    state_d      = state_q;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      // Kill everything, including a payload offered this cycle.
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (in_xfer) begin
            state_d    = S_ONE;
            ld_main_in = 1'b1;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            ld_main_in = 1'b1;
          end else if (in_xfer) begin
            state_d = S_TWO;
            ld_skid = 1'b1;
          end else if (out_xfer) begin
            state_d = S_EMPTY;
          end
        end
        S_TWO: begin
          if (out_xfer) begin
            state_d      = S_ONE;
            ld_main_skid = 1'b1;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      main_dat_q <= '0;
      skid_dat_q <= '0;
    end else begin
      if (ld_main_in) begin
        main_dat_q <= in_data;
      end else if (ld_main_skid) begin
        main_dat_q <= skid_dat_q;
      end
      if (ld_skid) begin
        skid_dat_q <= in_data;
      end
    end
  end

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
